feature_streamer: RTL
=====================

Name: feature_streamer

Overview:
Host-side companion to the HDC sensor-fusion core. It assembles feature frames from a narrow beat stream into the packed `features_top` vector and drives the core's `fin_valid`/`fin_ready` input handshake. It also sinks the core's `dout_valid`/`dout_ready` result stream of valence/arousal bits into a small result FIFO for the host. It sits between the host link and the fusion core top level.

Parameters:
- TOTAL_NUM_CHANNEL, 214, number of feature channels per frame.
- CHANNEL_WIDTH, 2, bits per channel.
- BUS_WIDTH, 8, host beat width; must be a multiple of CHANNEL_WIDTH. CPB = BUS_WIDTH/CHANNEL_WIDTH channels per beat.
- RESULT_DEPTH, 4, result FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  host beat valid.
- s_ready  out  1  host beat ready.
- s_data  in  BUS_WIDTH  CPB channels; lowest-index channel in the MSBs.
- s_last  in  1  last beat of the frame.
- fin_valid  out  1  frame valid to the core.
- fin_ready  in  1  core accepts the frame.
- features_top  out  TOTAL_NUM_CHANNEL*CHANNEL_WIDTH  packed frame; channel 0 in the top CHANNEL_WIDTH bits, channel k at bits [(T-k)*CW-1 -: CW], where T = TOTAL_NUM_CHANNEL and CW = CHANNEL_WIDTH.
- dout_valid  in  1  core result valid.
- dout_ready  out  1  result accepted.
- valence  in  1  core result bit.
- arousal  in  1  core result bit.
- r_valid  out  1  host result valid.
- r_ready  in  1  host result ready.
- r_data  out  2  {valence, arousal}.
- frame_err  out  1  sticky framing error; cleared only by rst.
- outstanding  out  8  frames sent minus results received.

Behaviour:
- BEATS = ceil(TOTAL_NUM_CHANNEL/CPB); 54 at default parameters.
  - The last beat may be partial; unused slots are its LSB-side slots and are ignored.
- Reset values:
  - fin_valid, dout_ready, r_valid, frame_err = 0.
  - s_ready = 0.
  - features_top = 0, outstanding = 0, beat counter = 0, FIFO empty.
  - State = FILL; s_ready rises in the first cycle after reset deassertion.
- FSM states: FILL, SEND, DROP.
- FILL:
  - s_ready = 1.
  - Each s_valid&&s_ready beat writes CPB channels at slot base beat_cnt*CPB into the frame register, then increments beat_cnt.
  - If s_last and beat_cnt == BEATS-1: go to SEND, beat_cnt = 0.
  - If s_last with beat_cnt < BEATS-1 (early last): set frame_err, beat_cnt = 0, stay in FILL, discard the partial frame.
  - If beat_cnt == BEATS-1 without s_last (missing last): set frame_err, go to DROP.
- DROP:
  - s_ready = 1; beats are discarded.
  - The beat carrying s_last returns the FSM to FILL with beat_cnt = 0.
- SEND:
  - s_ready = 0, fin_valid = 1.
  - features_top is stable while fin_valid is high.
  - On fin_valid&&fin_ready: fin_valid drops next cycle, outstanding increments, state goes to FILL.
  - Minimum gap between frames is BEATS+1 cycles; no double buffering.
- Result FIFO:
  - dout_ready = !full, a registered full flag.
  - Push on dout_valid&&dout_ready; pop on r_valid&&r_ready.
  - Simultaneous push and pop when full is not possible, because dout_ready is 0.
  - Simultaneous push and pop at any other occupancy keeps the count.
  - r_valid = !empty; r_data is the head entry.
  - Latency from push to r_valid is 1 cycle.
- outstanding:
  - +1 on fin handshake, −1 on dout handshake; both in the same cycle leaves it unchanged.
  - Saturates at 255 and never decrements below 0.
  - A dout handshake with outstanding == 0 sets frame_err.
- Reset mid-frame or mid-SEND aborts everything immediately, because reset is asynchronous; no partial frame is ever presented.
- The core is in-order, so results pair with frames in send order.

Optional Feature:
Macro: FEATURE_STREAMER_FRAME_ID_EN
- Defined:
  - Adds output r_id [7:0].
  - Each FIFO entry stores a result sequence number: 0 after reset, +1 per dout push, wrapping 255→0.
  - r_id shows the head entry's number and is stable with r_data.
- Undefined: no r_id port and no sequence counter; behaviour is otherwise identical.

Test Plan:
- Full frame: 54 beats with s_data = 8'b00_01_10_11 each, s_last on beat 54, fin_ready = 1 → fin_valid one cycle, features_top top byte = 8'h1B, outstanding = 1, frame_err = 0.
- Backpressure: fin_ready held 0 for 20 cycles after a frame → fin_valid stays 1, features_top unchanged, s_ready = 0; fin_ready = 1 → accepted, s_ready = 1 next cycle.
- Early s_last on beat 10 → frame_err = 1, no fin_valid. Next correct 54-beat frame is sent normally.
- Missing s_last: 60 beats with s_last on beat 60 → frame_err = 1, no fin_valid. The following good frame is sent.
- Result FIFO: send 5 frames, core returns 5 results {1,0},{0,1},{1,1},{0,0},{1,0} with r_ready = 0 → dout_ready = 0 after 4. r_ready = 1 → r_data delivered in order, then the 5th is accepted, outstanding = 0. With FEATURE_STREAMER_FRAME_ID_EN, r_id = 0..4.
- Reset mid-fill after 30 beats → all outputs at reset values. A fresh 54-beat frame is sent with correct packing.

Source files
------------

// File: rtl/feature_streamer.sv
// feature_streamer: assembles host beats into feature frames for the HDC core and buffers its results.
// Ports: s_* host beat stream in; fin_valid/fin_ready/features_top frame out to the core;
//        dout_valid/dout_ready/valence/arousal result stream from the core;
//        r_valid/r_ready/r_data result FIFO head to the host; frame_err sticky framing error;
//        outstanding = frames sent minus results received.
// Optional: define FEATURE_STREAMER_FRAME_ID_EN to add r_id, a per-result sequence number.
module feature_streamer #(
    parameter int TOTAL_NUM_CHANNEL = 214,
    parameter int CHANNEL_WIDTH     = 2,
    parameter int BUS_WIDTH         = 8,
    parameter int RESULT_DEPTH      = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    input  logic [BUS_WIDTH-1:0]                       s_data,
    input  logic                                       s_last,
    output logic                                       fin_valid,
    input  logic                                       fin_ready,
    output logic [TOTAL_NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
    input  logic                                       dout_valid,
    output logic                                       dout_ready,
    input  logic                                       valence,
    input  logic                                       arousal,
    output logic                                       r_valid,
    input  logic                                       r_ready,
    output logic [1:0]                                 r_data,
    output logic                                       frame_err,
    output logic [7:0]                                 outstanding
`ifdef FEATURE_STREAMER_FRAME_ID_EN
    ,
    output logic [7:0]                                 r_id
`endif
);
    localparam int T     = TOTAL_NUM_CHANNEL;
    localparam int CW    = CHANNEL_WIDTH;
    localparam int CPB   = BUS_WIDTH / CHANNEL_WIDTH;
    localparam int BEATS = (T + CPB - 1) / CPB;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FW    = T * CW;
    localparam int AW    = $clog2(RESULT_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {FILL, SEND, DROP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          live_q;
    logic          err_q, err_d;
    logic [7:0]    out_q, out_d;
    logic [1:0]    mem_q [RESULT_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q;
    logic          s_hs, fin_hs, push, pop;

    // live_q keeps both ready outputs low until the first clock after reset release
    assign s_ready      = live_q && state_q != SEND;
    assign fin_valid    = state_q == SEND;
    assign features_top = frame_q;
    assign dout_ready   = live_q && !full_q;
    assign r_valid      = cnt_q != '0;
    assign r_data       = mem_q[rp_q];
    assign frame_err    = err_q;
    assign outstanding  = out_q;
    assign s_hs         = s_valid && s_ready;
    assign fin_hs       = fin_valid && fin_ready;
    assign push         = dout_valid && dout_ready;
    assign pop          = r_valid && r_ready;
    assign cnt_d        = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        frame_d = frame_q;
        err_d   = err_q || (push && out_q == 8'd0);
        out_d   = (fin_hs && !push && out_q != 8'hff) ? out_q + 8'd1 :
                  (push && !fin_hs && out_q != 8'd0)  ? out_q - 8'd1 : out_q;
        case (state_q)
            FILL: if (s_hs) begin
                // slot j of the beat is channel beat*CPB+j; slots past the last channel are dropped
                for (int j = 0; j < CPB; j++)
                    if (int'(beat_q) * CPB + j < T)
                        frame_d[(T - int'(beat_q) * CPB - j) * CW - 1 -: CW] = s_data[(CPB - j) * CW - 1 -: CW];
                if (s_last) begin
                    beat_d  = '0;
                    state_d = (beat_q == LAST_BEAT) ? SEND : FILL;
                    err_d   = err_d || beat_q != LAST_BEAT;
                end else if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    err_d   = 1'b1;
                    state_d = DROP;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            SEND:    state_d = fin_ready ? FILL : SEND;
            DROP:    state_d = (s_hs && s_last) ? FILL : DROP;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            beat_q  <= '0;
            frame_q <= '0;
            live_q  <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            frame_q <= frame_d;
            live_q  <= 1'b1;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RESULT_DEPTH; i++) mem_q[i] <= 2'b00;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) mem_q[wp_q] <= {valence, arousal};
            if (push) wp_q <= wp_q + AW'(1);
            if (pop) rp_q <= rp_q + AW'(1);
            cnt_q  <= cnt_d;
            full_q <= cnt_d == (AW+1)'(RESULT_DEPTH);
        end
    end

`ifdef FEATURE_STREAMER_FRAME_ID_EN
    logic [7:0] seq_q;
    logic [7:0] id_q [RESULT_DEPTH];

    assign r_id = id_q[rp_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q <= 8'd0;
            for (int i = 0; i < RESULT_DEPTH; i++) id_q[i] <= 8'd0;
        end else if (push) begin
            id_q[wp_q] <= seq_q;
            seq_q      <= seq_q + 8'd1;
        end
    end
`endif
endmodule
